soc_mmio: RTL and testbench

//  Memory-side bridge between the mcu data port and the system RAM. Decodes each access

---
 rtl/soc_mmio.sv | 154 +++++++++++++++
 tb/tb_soc_mmio.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/soc_mmio.sv
// Memory-side bridge: routes mcu accesses to system RAM or a small MMIO block
// (GPIO, cycle counter, timer compare, status/irq) with a selectable byte order.
module soc_mmio #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter int unsigned IO_BIT    = 22,
   parameter int unsigned N_GPIO    = 2,
   parameter int unsigned SWAP_MODE = 1,
   parameter logic [31:0] RST_GPIO  = 32'h0000_0000,
   localparam int unsigned RAM_AW   = $clog2(RAM_WORDS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [31:0]           mem_addr,
   input  logic                  mem_rstrb,
   input  logic [3:0]            mem_wmask,
   input  logic [31:0]           mem_wdata,
   output logic [31:0]           mem_rdata,
   output logic [RAM_AW-1:0]     ram_addr,
   output logic                  ram_rstrb,
   output logic [3:0]            ram_wmask,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata,
   output logic [N_GPIO*32-1:0]  gpio_out,
   input  logic [31:0]           gpio_in,
   output logic [7:0]            led,
   output logic                  irq
);

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [3:0] brev4(input logic [3:0] m);
      return {m[0], m[1], m[2], m[3]};
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

   logic [N_GPIO*32-1:0] gpio_q, gpio_d;
   logic [31:0]          cycle_q, cycle_d;
   logic [31:0]          cmp_q, cmp_d;
   logic                 status_q, status_d;
   logic [31:0]          sync1_q, sync2_q;
   logic [31:0]          io_rdata_q, io_rdata_d;
   logic                 sel_io_q, sel_io_d;

   logic                 io_sel_s;
   logic                 io_wr_s;
   logic [3:0]           word_s;
   logic [31:0]          gpio_rd_s;
   logic [31:0]          rd_val_s;
   logic                 w1c_s;
   logic                 unused_s;

   assign io_sel_s = mem_addr[IO_BIT];
   assign io_wr_s  = io_sel_s && (mem_wmask != 4'b0000);
   assign word_s   = mem_addr[5:2];
   assign unused_s = ^{mem_addr};

   // RAM side is pure wiring; mode 2 reverses write data and byte lanes.
   assign ram_addr  = mem_addr[RAM_AW+1:2];
   assign ram_rstrb = mem_rstrb & ~io_sel_s;
   assign ram_wmask = io_sel_s ? 4'b0000 :
                      ((SWAP_MODE == 32'd2) ? brev4(mem_wmask) : mem_wmask);
   assign ram_wdata = (SWAP_MODE == 32'd2) ? bswap32(mem_wdata) : mem_wdata;

   assign mem_rdata = sel_io_q ? io_rdata_q :
                      ((SWAP_MODE >= 32'd1) ? bswap32(ram_rdata) : ram_rdata);
   assign gpio_out  = gpio_q;
   assign led       = ~gpio_q[7:0];
   assign irq       = status_q;

   // Read mux over the MMIO word map, sampling only pre-write register values.
   always_comb begin
      gpio_rd_s = 32'h0000_0000;
      for (int n = 0; n < int'(N_GPIO); n++) begin
         gpio_rd_s = (word_s == 4'(n)) ? gpio_q[32*n +: 32] : gpio_rd_s;
      end
      if (32'(word_s) < N_GPIO) begin
         rd_val_s = gpio_rd_s;
      end else begin
         case (word_s)
            4'd8:    rd_val_s = sync2_q;
            4'd9:    rd_val_s = cycle_q;
            4'd10:   rd_val_s = cmp_q;
            4'd11:   rd_val_s = {31'h0000_0000, status_q};
            default: rd_val_s = 32'h0000_0000;
         endcase
      end
   end

   // Next-state for MMIO registers; a compare match beats a same-cycle clear.
   always_comb begin
      gpio_d = gpio_q;
      for (int n = 0; n < int'(N_GPIO); n++) begin
         gpio_d[32*n +: 32] = (io_wr_s && (word_s == 4'(n))) ?
                              merge_bytes(gpio_q[32*n +: 32], mem_wdata, mem_wmask) :
                              gpio_q[32*n +: 32];
      end
      cycle_d = cycle_q + 32'd1;
      if (io_wr_s && (word_s == 4'd10)) begin
         cmp_d = merge_bytes(cmp_q, mem_wdata, mem_wmask);
      end else begin
         cmp_d = cmp_q;
      end
      w1c_s = io_wr_s && (word_s == 4'd11) && mem_wmask[0] && mem_wdata[0];
      if (cycle_q == cmp_q) begin
         status_d = 1'b1;
      end else if (w1c_s) begin
         status_d = 1'b0;
      end else begin
         status_d = status_q;
      end
      if (mem_rstrb) begin
         sel_io_d   = io_sel_s;
         io_rdata_d = io_sel_s ? rd_val_s : io_rdata_q;
      end else begin
         sel_io_d   = sel_io_q;
         io_rdata_d = io_rdata_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gpio_q     <= {N_GPIO{RST_GPIO}};
         cycle_q    <= 32'h0000_0000;
         cmp_q      <= 32'hFFFF_FFFF;
         status_q   <= 1'b0;
         sync1_q    <= 32'h0000_0000;
         sync2_q    <= 32'h0000_0000;
         io_rdata_q <= 32'h0000_0000;
         sel_io_q   <= 1'b1;
      end else begin
         gpio_q     <= gpio_d;
         cycle_q    <= cycle_d;
         cmp_q      <= cmp_d;
         status_q   <= status_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         io_rdata_q <= io_rdata_d;
         sel_io_q   <= sel_io_d;
      end
   end

endmodule

// File: tb/tb_soc_mmio.sv
// Directed bench for soc_mmio: one instance in read-swap mode, one in full-swap mode.
module tb_soc_mmio;
   localparam logic [31:0] IO = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] gpio_in;

   logic [31:0] rd1, rd2, wd1, wd2;
   logic [9:0]  ra1, ra2;
   logic        rs1, rs2, irq1, irq2;
   logic [3:0]  wm1, wm2;
   logic [63:0] go1, go2;
   logic [7:0]  led1, led2;

   int n_chk  = 0;
   int n_pass = 0;
   int n_cyc  = 0;
   int guard;
   int tgt;
   logic [31:0] exp_v;

   soc_mmio #(.SWAP_MODE(1)) d1 (
      .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(rd1),
      .ram_addr(ra1), .ram_rstrb(rs1), .ram_wmask(wm1), .ram_wdata(wd1),
      .ram_rdata(ram_rdata), .gpio_out(go1), .gpio_in(gpio_in), .led(led1), .irq(irq1));

   soc_mmio #(.SWAP_MODE(2)) d2 (
      .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(rd2),
      .ram_addr(ra2), .ram_rstrb(rs2), .ram_wmask(wm2), .ram_wdata(wd2),
      .ram_rdata(ram_rdata), .gpio_out(go2), .gpio_in(gpio_in), .led(led2), .irq(irq2));

   always #5 clk = ~clk;

   // Reference cycle count: edges seen with reset released.
   always @(posedge clk) begin
      if (!rstn) n_cyc = 0;
      else       n_cyc = n_cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_rstrb = 1'b0;
      mem_wmask = 4'b0000;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = 1'b0;
      tick();
      idle();
   endtask

   task automatic rd(input logic [31:0] a);
      mem_addr = a; mem_rstrb = 1'b1; mem_wmask = 4'b0000;
      tick();
      idle();
   endtask

   initial begin
      rstn = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0;
      gpio_in = 32'h0; idle();
      tick(); tick();
      chk("rst_rdata", {32'h0, rd1}, 64'h0);
      chk("rst_irq", {63'h0, irq1}, 64'h0);
      chk("rst_led", {56'h0, led1}, 64'hFF);
      chk("rst_wmask", {60'h0, wm1}, 64'h0);
      chk("rst_gpio", go1, 64'h0);
      rstn = 1'b1;

      // Timer compare at 20
      wr(IO | 32'h28, 32'd20, 4'b1111);
      guard = 0;
      while (n_cyc != 20 && guard < 200) begin tick(); guard++; end
      chk("timer_reach", 64'(n_cyc), 64'd20);
      chk("irq_before", {63'h0, irq1}, 64'h0);
      tick();
      chk("irq_after", {63'h0, irq1}, 64'h1);
      rd(IO | 32'h2C);
      chk("status_rd", {32'h0, rd1}, 64'h1);
      wr(IO | 32'h2C, 32'h1, 4'b0001);
      chk("w1c_clear", {63'h0, irq1}, 64'h0);
      tgt = n_cyc + 4;
      wr(IO | 32'h28, 32'(tgt), 4'b1111);
      guard = 0;
      while (n_cyc != tgt && guard < 200) begin tick(); guard++; end
      chk("irq_pre_match", {63'h0, irq1}, 64'h0);
      wr(IO | 32'h2C, 32'h1, 4'b0001);
      chk("set_wins", {63'h0, irq1}, 64'h1);

      // Cycle counter read returns value at the strobe edge
      exp_v = 32'(n_cyc);
      rd(IO | 32'h24);
      chk("cycle_rd", {32'h0, rd1}, {32'h0, exp_v});

      // GPIO byte writes
      wr(IO | 32'h0, 32'h0000_00A5, 4'b0001);
      chk("led_a5", {56'h0, led1}, 64'h5A);
      rd(IO | 32'h0);
      chk("gpio0_rd", {32'h0, rd1}, 64'hA5);
      wr(IO | 32'h0, 32'h1122_3344, 4'b0100);
      chk("gpio0_byte2", go1, 64'h0000_0000_0022_00A5);
      wr(IO | 32'h4, 32'hDEAD_BEEF, 4'b1111);
      chk("gpio1_out", go1, 64'hDEAD_BEEF_0022_00A5);
      chk("gpio_noswap_m2", go2, 64'hDEAD_BEEF_0022_00A5);
      rd(IO | 32'h0000_1000);
      chk("hi_bits_ignored", {32'h0, rd1}, 64'h0022_00A5);

      // Read and write of one register in the same cycle
      mem_addr = IO | 32'h4; mem_wdata = 32'h1234_5678; mem_wmask = 4'b1111; mem_rstrb = 1'b1;
      tick(); idle();
      chk("rw_prewrite", {32'h0, rd1}, 64'hDEAD_BEEF);
      rd(IO | 32'h4);
      chk("rw_post", {32'h0, rd1}, 64'h1234_5678);
      rd(IO | 32'h34);
      chk("word13", {32'h0, rd1}, 64'h0);
      wr(IO | 32'h30, 32'hFFFF_FFFF, 4'b1111);
      chk("unmapped_wr", go1, 64'h1234_5678_0022_00A5);

      // gpio_in synchroniser: two edges before it is visible
      gpio_in = 32'h5555_AAAA;
      tick();
      rd(IO | 32'h20);
      chk("gin_old", {32'h0, rd1}, 64'h0);
      rd(IO | 32'h20);
      chk("gin_new", {32'h0, rd1}, 64'h5555_AAAA);

      // RAM read path
      mem_addr = 32'h0000_0100; mem_rstrb = 1'b1; ram_rdata = 32'h1122_3344;
      #1;
      chk("ram_rstrb", {63'h0, rs1}, 64'h1);
      chk("ram_addr", {54'h0, ra1}, 64'h40);
      tick(); idle();
      chk("ram_swap1", {32'h0, rd1}, 64'h4433_2211);
      chk("ram_swap2", {32'h0, rd2}, 64'h4433_2211);
      tick();
      chk("ram_hold", {32'h0, rd1}, 64'h4433_2211);
      mem_addr = IO | 32'h0; mem_rstrb = 1'b1;
      #1;
      chk("io_no_ramstrb", {63'h0, rs1}, 64'h0);
      idle();

      // RAM write lane handling
      mem_addr = 32'h0000_0200; mem_wdata = 32'hAABB_CCDD; mem_wmask = 4'b0011;
      #1;
      chk("m2_wdata", {32'h0, wd2}, 64'hDDCC_BBAA);
      chk("m2_wmask", {60'h0, wm2}, 64'hC);
      chk("m1_wdata", {32'h0, wd1}, 64'hAABB_CCDD);
      chk("m1_wmask", {60'h0, wm1}, 64'h3);
      mem_addr = IO | 32'h200;
      #1;
      chk("io_wmask0", {60'h0, wm1}, 64'h0);
      idle();
      tick();

      // Reset in the middle of a read
      mem_addr = IO | 32'h4; mem_rstrb = 1'b1;
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_rdata", {32'h0, rd1}, 64'h0);
      chk("mid_rst_led", {56'h0, led1}, 64'hFF);
      chk("mid_rst_gpio", go1, 64'h0);
      tick();
      idle();
      rstn = 1'b1;
      tick();
      chk("post_rst_rdata", {32'h0, rd1}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
